// File: rtl/mult_share_arb.sv
// Round-robin arbiter that time-shares one iterative multiplier among NREQ requesters.
// Operands are latched at grant; the result returns with a one-cycle one-hot ack.
module mult_share_arb #(
  parameter int NREQ    = 2,
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [WIDTH*NREQ-1:0]   a_in,
  input  logic [WIDTH*NREQ-1:0]   b_in,
  output logic [NREQ-1:0]         ack,
  output logic [2*WIDTH-1:0]      res,
  output logic                    err,
  output logic                    busy,
  output logic                    mult_init,
  output logic [WIDTH-1:0]        mult_a,
  output logic [WIDTH-1:0]        mult_b,
  input  logic [2*WIDTH-1:0]      mult_pp,
  input  logic                    mult_done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_CLR   = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]         r_state;
  logic [IW-1:0]      r_ptr;
  logic [IW-1:0]      r_grant;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_res;
  logic               r_err;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;

  logic               w_pick_valid;
  logic [IW-1:0]      w_pick_idx;
  logic               w_timeout;
  logic [WIDTH-1:0]   w_a_sl [NREQ];
  logic [WIDTH-1:0]   w_b_sl [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign w_a_sl[gi] = a_in[gi*WIDTH +: WIDTH];
      assign w_b_sl[gi] = b_in[gi*WIDTH +: WIDTH];
      assign ack[gi]    = (r_state == S_RESP) && (r_grant == IW'(gi));
    end
  endgenerate

  // Scan offsets from the top down so the smallest offset from the pointer wins.
  always_comb begin : rr_pick
    int j;
    j            = 0;
    w_pick_valid = 1'b0;
    w_pick_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(r_ptr) + k) % NREQ;
      if (req[j]) begin
        w_pick_valid = 1'b1;
        w_pick_idx   = IW'(j);
      end
    end
  end

  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_err   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_valid) begin
            r_grant <= w_pick_idx;
            r_a     <= w_a_sl[w_pick_idx];
            r_b     <= w_b_sl[w_pick_idx];
            r_state <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= S_CLR;
        end
        S_CLR, S_WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          // The watchdog beats a done that arrives in the same cycle.
          if (w_timeout) begin
            r_res   <= '0;
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end else if (r_state == S_CLR) begin
            if (!mult_done) r_state <= S_WAIT;
          end else if (mult_done) begin
            r_res   <= mult_pp;
            r_err   <= 1'b0;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_ptr   <= (r_grant == IW'(NREQ - 1)) ? '0 : r_grant + IW'(1);
          r_res   <= '0;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign res       = r_res;
  assign err       = r_err;
  assign busy      = (r_state != S_IDLE);
  assign mult_init = (r_state == S_START);
  assign mult_a    = r_a;
  assign mult_b    = r_b;

endmodule

// File: tb/tb_mult_share_arb.sv
// Bench for mult_share_arb: a behavioural multiplier plus a transaction-level model of the
// arbiter checked every cycle, followed by directed scenarios and a randomized run.
module tb_mult_share_arb;
  localparam int NREQ    = 2;
  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [WIDTH*NREQ-1:0] a_in, b_in;
  logic [NREQ-1:0]       ack;
  logic [2*WIDTH-1:0]    res;
  logic                  err, busy, mult_init;
  logic [WIDTH-1:0]      mult_a, mult_b;
  logic [2*WIDTH-1:0]    mult_pp;
  logic                  mult_done;

  mult_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .ack(ack), .res(res), .err(err), .busy(busy), .mult_init(mult_init),
    .mult_a(mult_a), .mult_b(mult_b), .mult_pp(mult_pp), .mult_done(mult_done)
  );

  // Multiplier: k counts cycles since init was taken. done stays at its stale high value
  // for 'drop' cycles, goes low, then rises 'lat' cycles later with the new product.
  int         mk = 100000;
  int         drop = 0;
  int         lat = 1;
  logic [7:0] prod = 8'hA5;

  always @(posedge clk) begin
    if (mult_init) mk <= 0;
    else begin
      if (mk < 1000000) mk <= mk + 1;
      if (mk + 1 == drop + lat) prod <= mult_a * mult_b;
    end
  end
  assign mult_done = (mk < drop) ? 1'b1 : (mk >= drop + lat);
  assign mult_pp   = prod;

  // Transaction-level model state
  int         e = 0;
  int         m_busy = 0, m_g = 0, m_K = 0, m_grant = 0, m_ptr = 0, next_sample = 0;
  logic       m_err = 1'b0;
  logic [3:0] m_a = '0, m_b = '0;

  int n_pass = 0, n_total = 0;
  int n_init = 0, last_init_e = 0;
  int auto_drop = 1;
  logic [NREQ-1:0] ack_q[$];
  logic [7:0]      res_q[$];
  logic            err_q[$];
  int              lat_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s edge=%0d got=%0h expected=%0h", name, e, act, exp_v);
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return 0;
  endfunction

  task automatic clear_log();
    ack_q.delete(); res_q.delete(); err_q.delete(); lat_q.delete();
    n_init = 0;
  endtask

  // Advance one clock, update the model for the edge just taken, compare all outputs.
  task automatic step();
    int t;
    logic [NREQ-1:0] x_ack;
    logic [7:0]      x_res;
    logic            x_err, x_busy, x_init;
    @(negedge clk);
    e++;
    if (!rst) begin
      m_busy = 0; m_ptr = 0; m_a = '0; m_b = '0; next_sample = e + 1;
    end else begin
      if (m_busy != 0 && (e - m_g) > m_K + 1) begin
        m_busy = 0; m_ptr = (m_grant + 1) % NREQ; next_sample = e + 1;
      end
      if (m_busy == 0 && e >= next_sample && req != '0) begin
        m_grant = rr_pick(req, m_ptr);
        m_a = a_in[m_grant*WIDTH +: WIDTH];
        m_b = b_in[m_grant*WIDTH +: WIDTH];
        m_g = e;
        if (drop + lat >= TIMEOUT - 1) begin m_err = 1'b1; m_K = TIMEOUT; end
        else begin m_err = 1'b0; m_K = drop + lat + 1; end
        m_busy = 1;
      end
    end
    x_ack = '0; x_res = '0; x_err = 1'b0; x_busy = 1'b0; x_init = 1'b0;
    if (m_busy != 0) begin
      t = e - m_g;
      x_busy = 1'b1;
      x_init = (t == 0);
      if (t == m_K + 1) begin
        x_ack[m_grant] = 1'b1;
        x_res = m_err ? 8'h00 : m_a * m_b;
        x_err = m_err;
      end
    end
    check("busy", busy, x_busy);
    check("mult_init", mult_init, x_init);
    check("ack", ack, x_ack);
    check("res", res, x_res);
    check("err", err, x_err);
    check("mult_a", mult_a, m_a);
    check("mult_b", mult_b, m_b);
    if (mult_init) begin n_init++; last_init_e = e; end
    if (ack != '0) begin
      ack_q.push_back(ack); res_q.push_back(res); err_q.push_back(err);
      lat_q.push_back(e - last_init_e);
      $display("edge %0d: ack=%b res=%02h err=%0b", e, ack, res, err);
      if (auto_drop != 0) req = req & ~ack;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b0; req = '0;
    step();
    rst = 1'b1;
    clear_log();
  endtask

  task automatic run_acks(input int n, input int max_cycles);
    int c;
    c = 0;
    while (ack_q.size() < n && c < max_cycles) begin step(); c++; end
    if (ack_q.size() < n) check("ack_wait", ack_q.size(), n);
  endtask

  initial begin
    rst = 1'b0; req = '0; a_in = '0; b_in = '0;
    step(); step();
    rst = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_res", res, 0);
    check("rst_err", err, 0);
    check("rst_init", mult_init, 0);
    check("rst_mult_a", mult_a, 0);
    check("rst_mult_b", mult_b, 0);

    // Single request, ideal multiplier
    reset_dut();
    drop = 0; lat = 1; auto_drop = 1;
    a_in = 8'h0A; b_in = 8'h0A; req = 2'b01;
    run_acks(1, 100);
    check("s1_ack", ack_q[0], 2'b01);
    check("s1_res", res_q[0], 8'h64);
    check("s1_err", err_q[0], 0);
    check("s1_init_to_ack", lat_q[0], 3);
    check("s1_init_pulses", n_init, 1);
    step();
    check("s1_busy_after", busy, 0);
    check("s1_mult_a_hold", mult_a, 4'hA);

    // Contention
    reset_dut();
    a_in = {4'hF, 4'h3}; b_in = {4'hF, 4'h5}; req = 2'b11;
    run_acks(2, 200);
    check("s2_first_ack", ack_q[0], 2'b01);
    check("s2_first_res", res_q[0], 8'h0F);
    check("s2_second_ack", ack_q[1], 2'b10);
    check("s2_second_res", res_q[1], 8'hE1);

    // Fairness with requests held high
    reset_dut();
    auto_drop = 0; req = 2'b11;
    run_acks(6, 400);
    for (int i = 0; i < 6; i++) check("s3_rotation", ack_q[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    req = '0; auto_drop = 1;
    for (int i = 0; i < 3; i++) step();

    // Stale done from the previous run
    reset_dut();
    drop = 2; lat = 3;
    a_in = 8'h07; b_in = 8'h09; req = 2'b01;
    run_acks(1, 100);
    check("s4_res", res_q[0], 8'h3F);
    check("s4_err", err_q[0], 0);
    check("s4_init_to_ack", lat_q[0], 7);

    // Timeout, then a normal completion
    reset_dut();
    drop = 0; lat = 500000;
    a_in = 8'h05; b_in = 8'h05; req = 2'b01;
    run_acks(1, 200);
    check("s5_ack", ack_q[0], 2'b01);
    check("s5_err", err_q[0], 1);
    check("s5_res", res_q[0], 8'h00);
    check("s5_init_to_ack", lat_q[0], 65);
    lat = 1;
    clear_log();
    a_in = 8'h40; b_in = 8'h40; req = 2'b10;
    run_acks(1, 100);
    check("s5_next_ack", ack_q[0], 2'b10);
    check("s5_next_res", res_q[0], 8'h10);
    check("s5_next_err", err_q[0], 0);

    // Reset while waiting on the multiplier
    reset_dut();
    drop = 0; lat = 30;
    a_in = 8'h03; b_in = 8'h03; req = 2'b01;
    for (int i = 0; i < 8; i++) step();
    rst = 1'b0; req = '0;
    step();
    rst = 1'b1;
    check("s6_busy", busy, 0);
    check("s6_mult_a", mult_a, 0);
    check("s6_res", res, 0);
    clear_log();
    for (int i = 0; i < 40; i++) step();
    check("s6_no_ack", ack_q.size(), 0);
    lat = 1;
    a_in = 8'h20; b_in = 8'h60; req = 2'b10;
    run_acks(1, 100);
    check("s6_ack", ack_q[0], 2'b10);
    check("s6_res_after", res_q[0], 8'h0C);

    // Randomized traffic; the per-cycle model does the checking
    reset_dut();
    auto_drop = 1;
    for (int c = 0; c < 4000; c++) begin
      a_in = 8'($urandom);
      b_in = 8'($urandom);
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
      if (m_busy == 0 && $urandom_range(0, 7) == 0) begin
        drop = $urandom_range(0, 3);
        lat  = ($urandom_range(0, 15) == 0) ? 70 : $urandom_range(1, 6);
      end
      rst = ($urandom_range(0, 599) != 0);
      step();
    end
    rst = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
